hpdcache_mux_arbiter: RTL

//   Round-robin arbiter/sequencer sharing one downstream channel between NREQ requesters.

---
 rtl/hpdcache_mux_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/hpdcache_mux_arbiter.sv
// Round-robin arbiter that drives the one-hot select of a downstream hpdcache_mux.
// It also relays valid/ready, and keeps the grant locked across multi-beat bursts until the last beat is accepted.
module hpdcache_mux_arbiter #(
  parameter  int unsigned NREQ    = 4,
  parameter  int unsigned BEATS_W = 4,
  localparam int unsigned IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NREQ-1:0]    req_valid_i,
  input  logic [NREQ-1:0]    req_last_i,
  output logic [NREQ-1:0]    req_ready_o,
  output logic [NREQ-1:0]    gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               valid_o,
  output logic               last_o,
  input  logic               ready_i,
  output logic               busy_o,
  output logic [BEATS_W-1:0] beat_cnt_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
  logic [BEATS_W-1:0] beat_cnt_q, beat_cnt_d;

  logic [IDX_W-1:0]   rr_winner;
  logic               rr_found;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   ptr_inc;
  logic               has_gnt;
  logic               win_valid;
  logic               win_last;
  logic               xfer;
  logic [NREQ-1:0]    gnt_onehot;

  // Search starts at rr_ptr and wraps at NREQ, so any NREQ (not just powers of 2) works.
  always_comb begin : rr_search
    logic [IDX_W:0] cand;
    rr_found  = 1'b0;
    rr_winner = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NREQ)) begin
        cand = cand - (IDX_W+1)'(NREQ);
      end
      if (!rr_found && req_valid_i[cand[IDX_W-1:0]]) begin
        rr_found  = 1'b1;
        rr_winner = cand[IDX_W-1:0];
      end
    end
  end

  assign winner    = (state_q == ST_LOCKED) ? lock_idx_q : rr_winner;
  assign has_gnt   = (state_q == ST_LOCKED) | rr_found;
  assign win_valid = has_gnt & req_valid_i[winner];
  assign win_last  = has_gnt & req_last_i[winner];
  assign xfer      = win_valid & ready_i;
  assign ptr_inc   = (winner == IDX_W'(NREQ - 1)) ? '0 : winner + 1'b1;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
    assign gnt_onehot[gi] = has_gnt & (winner == IDX_W'(gi));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Any presented-but-unaccepted beat locks the grant, so a winner is never revoked.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (rr_found) begin
          if (xfer && win_last) begin
            rr_ptr_d = ptr_inc;
          end else begin
            state_d    = ST_LOCKED;
            lock_idx_d = winner;
          end
        end
      end
      ST_LOCKED: begin
        if (xfer && win_last) begin
          state_d  = ST_IDLE;
          rr_ptr_d = ptr_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (xfer) begin
      if (win_last) begin
        beat_cnt_d = '0;
      end else if (beat_cnt_q != {BEATS_W{1'b1}}) begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    req_ready_o = '0;
    valid_o     = 1'b0;
    last_o      = 1'b0;
    busy_o      = 1'b0;
    beat_cnt_o  = '0;
    if (!rst_i) begin
      gnt_o       = gnt_onehot;
      gnt_idx_o   = has_gnt ? winner : '0;
      req_ready_o = gnt_onehot & {NREQ{ready_i}};
      valid_o     = win_valid;
      last_o      = win_last;
      busy_o      = (state_q == ST_LOCKED);
      beat_cnt_o  = beat_cnt_q;
    end
  end

endmodule
